// File: rtl/cos_th2_solver_if.sv
// Start/result handshake bundle for cos_th2_solver.
// COS_TH2_DOUBLE_OUT_EN adds the IEEE-754 double copy of the result.
interface cos_th2_solver_if #(
    parameter int W        = 32,
    parameter int OUT_FRAC = 30
);
    logic                       start;
    logic signed [W-1:0]        x;
    logic signed [W-1:0]        y;
    logic                       busy;
    logic                       done;
    logic signed [OUT_FRAC+1:0] cos_th2;
    logic                       unreachable;
`ifdef COS_TH2_DOUBLE_OUT_EN
    logic [63:0]                cos_th2_dbl;

    modport master (output start, x, y, input busy, done, cos_th2, unreachable, cos_th2_dbl);
    modport slave  (input start, x, y, output busy, done, cos_th2, unreachable, cos_th2_dbl);
`else
    modport master (output start, x, y, input busy, done, cos_th2, unreachable);
    modport slave  (input start, x, y, output busy, done, cos_th2, unreachable);
`endif
endinterface

// File: rtl/cos_th2_solver.sv
// cos(theta2) = (x^2+y^2-L1^2-L2^2)/(2*L1*L2) with reach saturation and a bit-serial restoring divide.
// Optional macro COS_TH2_DOUBLE_OUT_EN: extra registered cycle producing cos_th2_dbl (IEEE-754 double).
module cos_th2_solver #(
    parameter int          W        = 32,
    parameter int          FRAC     = 16,
    parameter int          OUT_FRAC = 30,
    // 0.3125 and 0.25 in Q.FRAC
    parameter int unsigned L1_Q     = 32'd5 << (FRAC - 4),
    parameter int unsigned L2_Q     = 32'd1 << (FRAC - 2)
) (
    input logic             clk,
    input logic             reset,
    cos_th2_solver_if.slave bus
);
    localparam int NW = 2 * W + 2;
    localparam int OW = OUT_FRAC + 2;
    localparam int CW = $clog2(OUT_FRAC + 1);

    localparam logic [2*W-1:0]       L1_E   = (2 * W)'(L1_Q);
    localparam logic [2*W-1:0]       L2_E   = (2 * W)'(L2_Q);
    localparam logic [NW-1:0]        K_E    = {2'b00, L1_E * L1_E + L2_E * L2_E};
    localparam logic [NW-1:0]        D_E    = {2'b00, (L1_E * L2_E) << 1};
    localparam logic signed [OW-1:0] PLUS1  = OW'(1) << OUT_FRAC;
    localparam logic signed [OW-1:0] MINUS1 = -PLUS1;
    localparam logic [CW-1:0]        LAST   = CW'(OUT_FRAC - 1);

    typedef enum logic [2:0] {IDLE, SQUARE, SUM, CHECK, DIV, FINISH, CONV} state_t;
    state_t state, state_n;

    logic signed [W-1:0]   x_r, y_r;
    logic signed [2*W-1:0] x_ext, y_ext;
    logic [2*W-1:0]        xx, yy;
    logic signed [NW-1:0]  num;
    logic [NW-1:0]         abs_num, rem, rem_sh;
    logic [OUT_FRAC-1:0]   quo;
    logic signed [OW-1:0]  q_ext;
    logic [CW-1:0]         cnt;
    logic                  sat;

    logic                  res_rdy, publish, unr_n;
    logic signed [OW-1:0]  res_n;
    logic                  done_r, unr_out;
    logic signed [OW-1:0]  cos_out;

    assign x_ext   = (2 * W)'(x_r);
    assign y_ext   = (2 * W)'(y_r);
    assign abs_num = num[NW-1] ? -num : num;
    assign rem_sh  = {rem[NW-2:0], 1'b0};
    assign q_ext   = {2'b00, quo};
    assign sat     = (abs_num >= D_E);

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.cos_th2     = cos_out;
    assign bus.unreachable = unr_out;

`ifdef COS_TH2_DOUBLE_OUT_EN
    logic signed [OW-1:0] res_r;
    logic                 unr_r;
    logic [63:0]          dbl_out;

    assign bus.cos_th2_dbl = dbl_out;

    // Fixed-point value v / 2^OUT_FRAC is exactly representable; normalise on the leading one.
    function automatic logic [63:0] to_double(input logic signed [OW-1:0] v);
        logic [OW-1:0] mag;
        logic [51:0]   mant;
        int            p;
        mag = v[OW-1] ? -v : v;
        p   = 0;
        for (int i = 0; i < OW; i++) begin
            if (mag[i]) p = i;
        end
        mant = 52'(64'(mag) << (52 - p));
        if (mag == '0) to_double = 64'h0;
        else           to_double = {v[OW-1], 11'(1023 + p - OUT_FRAC), mant};
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        res_rdy = 1'b0;
        publish = 1'b0;
        res_n   = '0;
        unr_n   = 1'b0;
        case (state)
            IDLE:   if (bus.start) state_n = SQUARE;
            SQUARE: state_n = SUM;
            SUM:    state_n = CHECK;
            CHECK: begin
                if (sat) begin
                    res_rdy = 1'b1;
                    res_n   = num[NW-1] ? MINUS1 : PLUS1;
                    unr_n   = (abs_num > D_E);
                end else begin
                    state_n = DIV;
                end
            end
            DIV:    if (cnt == LAST) state_n = FINISH;
            FINISH: begin
                res_rdy = 1'b1;
                res_n   = num[NW-1] ? -q_ext : q_ext;
            end
            CONV: begin
                publish = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef COS_TH2_DOUBLE_OUT_EN
        if (res_rdy) state_n = CONV;
`else
        if (res_rdy) begin
            publish = 1'b1;
            state_n = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r     <= '0;
            y_r     <= '0;
            xx      <= '0;
            yy      <= '0;
            num     <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            done_r  <= 1'b0;
            cos_out <= '0;
            unr_out <= 1'b0;
`ifdef COS_TH2_DOUBLE_OUT_EN
            res_r   <= '0;
            unr_r   <= 1'b0;
            dbl_out <= '0;
`endif
        end else begin
            done_r <= publish;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_r <= bus.x;
                        y_r <= bus.y;
                    end
                end
                SQUARE: begin
                    xx <= $unsigned(x_ext * x_ext);
                    yy <= $unsigned(y_ext * y_ext);
                end
                SUM:   num <= $signed({2'b00, xx}) + $signed({2'b00, yy}) - $signed(K_E);
                CHECK: begin
                    rem <= abs_num;
                    quo <= '0;
                    cnt <= '0;
                end
                // Remainder stays below D, so each shifted trial fits in NW bits.
                DIV: begin
                    if (rem_sh >= D_E) begin
                        rem <= rem_sh - D_E;
                        quo <= {quo[OUT_FRAC-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[OUT_FRAC-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
`ifdef COS_TH2_DOUBLE_OUT_EN
            if (res_rdy) begin
                res_r <= res_n;
                unr_r <= unr_n;
            end
            if (publish) begin
                cos_out <= res_r;
                unr_out <= unr_r;
                dbl_out <= to_double(res_r);
            end
`else
            if (publish) begin
                cos_out <= res_n;
                unr_out <= unr_n;
            end
`endif
        end
    end
endmodule

// File: tb/tb_cos_th2_solver.sv
// Scoreboard bench for cos_th2_solver: directed targets queued at issue, checked by a done-driven monitor.
module tb_cos_th2_solver;
`ifdef COS_TH2_DOUBLE_OUT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT_SAT = 3 + EXTRA;
    localparam int LAT_DIV = 34 + EXTRA;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cos_th2_solver_if #(.W(32), .OUT_FRAC(30)) bus ();

    cos_th2_solver dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string              name;
        logic signed [31:0] cos;
        logic               unr;
        int                 lat;
        int                 t0;
    } exp_t;

    exp_t sb[$];
    int   ntests   = 0;
    int   nfail    = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        ntests++;
        if (act !== exp_v) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_one_cycle", 64'(bus.done), 64'd0);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_done: got done with cos_th2=%0h, expected no done", bus.cos_th2);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_cos"}, 64'(bus.cos_th2), 64'(e.cos));
                    check({e.name, "_unr"}, 64'(bus.unreachable), 64'(e.unr));
                    check({e.name, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
                    check({e.name, "_busy_low"}, 64'(bus.busy), 64'd0);
                    check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
`ifdef COS_TH2_DOUBLE_OUT_EN
                    check({e.name, "_dbl"}, bus.cos_th2_dbl, $realtobits(real'(e.cos) / 1073741824.0));
`endif
                end
                busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    task automatic issue(input string nm, input logic signed [31:0] xi, input logic signed [31:0] yi,
                         input logic signed [31:0] ec, input logic eu, input bit div, input bit expect_done);
        int   guard;
        exp_t e;
        guard = 0;
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            ntests++;
            nfail++;
            $display("FAIL %s_idle_wait: busy still %0b after %0d cycles, expected 0", nm, bus.busy, guard);
        end
        bus.x     = xi;
        bus.y     = yi;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (expect_done) begin
            e.name = nm;
            e.cos  = ec;
            e.unr  = eu;
            e.lat  = div ? LAT_DIV : LAT_SAT;
            e.t0   = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic check_cleared(input string nm);
        check({nm, "_cos"}, 64'(bus.cos_th2), 64'd0);
        check({nm, "_unr"}, 64'(bus.unreachable), 64'd0);
        check({nm, "_done"}, 64'(bus.done), 64'd0);
        check({nm, "_busy"}, 64'(bus.busy), 64'd0);
`ifdef COS_TH2_DOUBLE_OUT_EN
        check({nm, "_dbl"}, bus.cos_th2_dbl, 64'd0);
`endif
    endtask

    initial begin
        int guard;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        @(negedge clk);

        // Saturating targets: exact reach limits, origin, just outside, extreme magnitudes.
        issue("reach_max",  32'sd36864,  32'sd0,      32'sh40000000, 1'b0, 1'b0, 1'b1);
        issue("reach_min",  32'sd4096,   32'sd0,      32'shC0000000, 1'b0, 1'b0, 1'b1);
        issue("origin",     32'sd0,      32'sd0,      32'shC0000000, 1'b1, 1'b0, 1'b1);
        issue("just_out",   32'sd36865,  32'sd0,      32'sh40000000, 1'b1, 1'b0, 1'b1);
        issue("huge",      -32'sd2147483647, -32'sd2147483647, 32'sh40000000, 1'b1, 1'b0, 1'b1);

        // In-range targets: q = |num|*8/5 truncated, since D = 5*2^27.
        issue("zero",       32'sd20480, -32'sd16384,  32'sd0,           1'b0, 1'b1, 1'b1);
        issue("just_in",    32'sd36863,  32'sd0,      32'sd1073623860,  1'b0, 1'b1, 1'b1);
        issue("neg_in",     32'sd0,      32'sd26000, -32'sd18985369,    1'b0, 1'b1, 1'b1);
        issue("mid",       -32'sd26000,  32'sd12000,  32'sd211414630,   1'b0, 1'b1, 1'b1);

        // Start pulsed while busy must be dropped.
        repeat (9) @(negedge clk);
        bus.x     = 32'sd36864;
        bus.y     = 32'sd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset in the middle of a divide aborts it with no done.
        issue("pre_reset",  32'sd36864,  32'sd0,      32'sh40000000, 1'b0, 1'b0, 1'b1);
        issue("aborted",    32'sd20480,  32'sd16384,  32'sd0,        1'b0, 1'b1, 1'b0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_cleared("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        issue("post_reset", -32'sd26000, 32'sd12000,  32'sd211414630, 1'b0, 1'b1, 1'b1);

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            ntests++;
            nfail++;
            $display("FAIL drain: %0d results outstanding after %0d cycles, expected 0", sb.size(), guard);
        end
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
